// File: rtl/instr_loader.sv
// Program loader: turns a host byte stream (16-bit LE word count, then LE 32-bit words) into instruction-memory writes.
// Latency: one write cycle after each 4th data byte; byte_ready drops in IDLE/WRITE/DONE/ERR so the sender holds data.
module instr_loader #(
    parameter int MEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        mem_w_en,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_w_data,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        err
);
    localparam int IW = $clog2(MEM_WORDS + 1);

    typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, WRITE, DONE, ERR} state_t;

    state_t        state_q, state_d;
    logic [15:0]   len_q, len_d;
    logic [IW-1:0] word_idx_q, word_idx_d;
    logic [1:0]    byte_idx_q, byte_idx_d;
    logic [23:0]   word_q, word_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [31:0]   mem_w_data_q, mem_w_data_d;
    logic          byte_ready_q, byte_ready_d;
    logic          mem_w_en_q, mem_w_en_d;
    logic          cpu_hold_q, cpu_hold_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic          accept;
    logic [15:0]   len_full;
    logic [IW-1:0] word_idx_inc;

    assign accept       = byte_valid & byte_ready_q;
    assign len_full     = {byte_data, len_q[7:0]};
    assign word_idx_inc = word_idx_q + IW'(1);

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        word_idx_d   = word_idx_q;
        byte_idx_d   = byte_idx_q;
        word_d       = word_q;
        mem_addr_d   = mem_addr_q;
        mem_w_data_d = mem_w_data_q;

        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d    = LEN0;
                    len_d      = '0;
                    word_idx_d = '0;
                    byte_idx_d = '0;
                    word_d     = '0;
                end
            end
            LEN0: begin
                if (accept) begin
                    len_d   = {8'h00, byte_data};
                    state_d = LEN1;
                end
            end
            LEN1: begin
                if (accept) begin
                    len_d      = len_full;
                    word_idx_d = '0;
                    byte_idx_d = '0;
                    if (len_full == 16'd0 || len_full > 16'(MEM_WORDS)) state_d = ERR;
                    else                                                  state_d = DATA;
                end
            end
            DATA: begin
                if (accept) begin
                    byte_idx_d = byte_idx_q + 2'd1;
                    case (byte_idx_q)
                        2'd0: word_d[7:0]   = byte_data;
                        2'd1: word_d[15:8]  = byte_data;
                        2'd2: word_d[23:16] = byte_data;
                        default: begin
                            // Last lane goes straight into the write register; no need to store it.
                            mem_w_data_d = {byte_data, word_q};
                            mem_addr_d   = 32'({word_idx_q, 2'b00});
                            state_d      = WRITE;
                        end
                    endcase
                end
            end
            WRITE: begin
                word_idx_d = word_idx_inc;
                byte_idx_d = '0;
                if (16'(word_idx_inc) == len_q) state_d = DONE;
                else                            state_d = DATA;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered decodes of the next state.
        byte_ready_d = (state_d == LEN0) || (state_d == LEN1) || (state_d == DATA);
        mem_w_en_d   = (state_d == WRITE);
        busy_d       = (state_d == LEN0) || (state_d == LEN1) || (state_d == DATA) || (state_d == WRITE);
        done_d       = (state_d == DONE);
        err_d        = (state_d == ERR);
        cpu_hold_d   = (state_d != DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            len_q        <= '0;
            word_idx_q   <= '0;
            byte_idx_q   <= '0;
            word_q       <= '0;
            mem_addr_q   <= '0;
            mem_w_data_q <= '0;
            byte_ready_q <= 1'b0;
            mem_w_en_q   <= 1'b0;
            cpu_hold_q   <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            word_idx_q   <= word_idx_d;
            byte_idx_q   <= byte_idx_d;
            word_q       <= word_d;
            mem_addr_q   <= mem_addr_d;
            mem_w_data_q <= mem_w_data_d;
            byte_ready_q <= byte_ready_d;
            mem_w_en_q   <= mem_w_en_d;
            cpu_hold_q   <= cpu_hold_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign byte_ready = byte_ready_q;
    assign mem_w_en   = mem_w_en_q;
    assign mem_addr   = mem_addr_q;
    assign mem_w_data = mem_w_data_q;
    assign cpu_hold   = cpu_hold_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader: scoreboard of expected memory writes, popped by a write monitor.
module tb_instr_loader;
    logic        clk;
    logic        rst;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_w_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_w_data;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        err;

    instr_loader #(.MEM_WORDS(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .mem_w_en   (mem_w_en),
        .mem_addr   (mem_addr),
        .mem_w_data (mem_w_data),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         mon_e;
    logic [31:0] prog [64];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          wen_count = 0;
    int          wen_base;
    bit          ok;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, act, expv);
        end
    endtask

    // Write monitor: every mem_w_en cycle must match the head of the scoreboard.
    always @(negedge clk) begin
        if (mem_w_en === 1'b1) begin
            wen_count++;
            if (exp_q.size() == 0) begin
                chk("unexpected_write", mem_addr, 32'hFFFF_FFFF);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", mem_addr, mon_e.addr);
                chk("wr_data", mem_w_data, mon_e.data);
            end
        end
    end

    // Called at a negedge; returns at the negedge just after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input int gap, output bit acc);
        acc = 1'b0;
        for (int g = 0; g < gap; g++) begin
            byte_valid = 1'b0;
            @(negedge clk);
        end
        byte_valid = 1'b1;
        byte_data  = b;
        for (int i = 0; i < 50; i++) begin
            if (byte_ready === 1'b1) begin
                @(negedge clk);
                acc = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic load_stream(input logic [15:0] len, input int nwords, input int gap);
        bit a;
        send_byte(len[7:0], gap, a);
        send_byte(len[15:8], gap, a);
        for (int w = 0; w < nwords; w++) begin
            exp_q.push_back({32'(w) << 2, prog[w]});
            for (int k = 0; k < 4; k++) begin
                send_byte(prog[w][8*k +: 8], gap, a);
            end
            chk("wen_after_4th", {31'd0, mem_w_en}, 32'd1);
            chk("ready_in_write", {31'd0, byte_ready}, 32'd0);
        end
        byte_valid = 1'b0;
    endtask

    task automatic check_done(input string tag, input int nwr);
        @(negedge clk);
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_hold"}, {31'd0, cpu_hold}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_nwr"}, 32'(wen_count - wen_base), 32'(nwr));
        chk({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, byte_ready}, 32'd0);
        chk("rst_wen", {31'd0, mem_w_en}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_w_data, 32'd0);
        chk("rst_flags", {28'd0, cpu_hold, busy, done, err}, 32'b1000);
        rst = 1'b1;
        @(negedge clk);

        // len=2, back-to-back; first byte offered together with start must not be consumed in IDLE.
        prog[0] = 32'h0050_0013;
        prog[1] = 32'h0052_00B3;
        wen_base = wen_count;
        start = 1'b1; byte_valid = 1'b1; byte_data = 8'h02;
        @(negedge clk);
        start = 1'b0;
        chk("len0_ready", {31'd0, byte_ready}, 32'd1);
        chk("len0_busy", {31'd0, busy}, 32'd1);
        load_stream(16'd2, 2, 0);
        check_done("bb", 2);

        // Restart from DONE, then the same stream with valid gaps.
        wen_base = wen_count;
        pulse_start();
        chk("restart_flags", {28'd0, cpu_hold, busy, done, err}, 32'b1100);
        load_stream(16'd2, 2, 2);
        check_done("gap", 2);

        // Zero length.
        wen_base = wen_count;
        pulse_start();
        send_byte(8'h00, 0, ok);
        send_byte(8'h00, 0, ok);
        chk("len0_flags", {28'd0, cpu_hold, busy, done, err}, 32'b1001);
        byte_data = 8'hAA;
        repeat (4) @(negedge clk);
        chk("len0_ready", {31'd0, byte_ready}, 32'd0);
        byte_valid = 1'b0;
        chk("len0_nwr", 32'(wen_count - wen_base), 32'd0);

        // MEM_WORDS+1, restarting from ERR.
        pulse_start();
        chk("err_restart", {28'd0, cpu_hold, busy, done, err}, 32'b1100);
        send_byte(8'h41, 0, ok);
        send_byte(8'h00, 0, ok);
        byte_valid = 1'b0;
        @(negedge clk);
        chk("len65_err", {31'd0, err}, 32'd1);
        chk("len65_hold", {31'd0, cpu_hold}, 32'd1);
        chk("len65_nwr", 32'(wen_count - wen_base), 32'd0);

        // Full memory.
        for (int i = 0; i < 64; i++) prog[i] = $urandom();
        wen_base = wen_count;
        pulse_start();
        load_stream(16'd64, 64, 0);
        check_done("full", 64);
        chk("full_last_addr", mem_addr, 32'h0000_00FC);
        chk("full_last_data", mem_w_data, prog[63]);

        // Reset mid-load: word 0 written, word 1 partially assembled then discarded.
        prog[0] = 32'h0050_0013;
        prog[1] = 32'h0052_00B3;
        wen_base = wen_count;
        pulse_start();
        exp_q.push_back({32'h0, prog[0]});
        send_byte(8'h02, 0, ok);
        send_byte(8'h00, 0, ok);
        for (int k = 0; k < 4; k++) send_byte(prog[0][8*k +: 8], 0, ok);
        send_byte(prog[1][7:0], 0, ok);
        rst = 1'b0;
        byte_valid = 1'b0;
        @(negedge clk);
        chk("mid_rst_flags", {28'd0, cpu_hold, busy, done, err}, 32'b1000);
        chk("mid_rst_ready", {31'd0, byte_ready}, 32'd0);
        chk("mid_rst_addr", mem_addr, 32'd0);
        chk("mid_rst_wdata", mem_w_data, 32'd0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("mid_rst_nwr", 32'(wen_count - wen_base), 32'd1);
        chk("mid_rst_sb", 32'(exp_q.size()), 32'd0);
        wen_base = wen_count;
        pulse_start();
        load_stream(16'd2, 2, 1);
        check_done("reload", 2);

        // One-word program after DONE.
        prog[0] = 32'hDEAD_BEEF;
        wen_base = wen_count;
        pulse_start();
        chk("one_restart", {28'd0, cpu_hold, busy, done, err}, 32'b1100);
        load_stream(16'd1, 1, 0);
        check_done("one", 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
